// File: rtl/recv_word_buffer.sv
// rtl/recv_word_buffer.sv - byte-to-word assembler feeding a show-ahead receive FIFO (optional RECV_BYTESWAP_EN)
module recv_word_buffer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_byte_valid,
  input  logic                       recv_pop,
  output logic [31:0]                recv_data,
  output logic                       recv_valid,
  output logic [$clog2(DEPTH):0]     recv_count,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [31:0]     asm_q, asm_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     mem_q [DEPTH];

  logic [1:0]      lane;
  logic [31:0]     word;
  logic            complete;
  logic            full;
  logic            pop;
  logic            push;
  logic            ovf_set;

  // Byte lane for the byte accepted in the current assembler state
  always_comb begin
`ifdef RECV_BYTESWAP_EN
    lane = state_q;
`else
    lane = 2'd3 - state_q;
`endif
  end

  // Assembler FSM: merge incoming byte, advance state, run the idle timeout
  always_comb begin
    state_d  = state_q;
    asm_d    = asm_q;
    idle_d   = idle_q;
    complete = 1'b0;
    word     = asm_q;
    word[{lane, 3'b000} +: 8] = rx_byte;
    if (rx_byte_valid) begin
      idle_d = '0;
      case (state_q)
        B0: begin state_d = B1; asm_d = word; end
        B1: begin state_d = B2; asm_d = word; end
        B2: begin state_d = B3; asm_d = word; end
        default: begin
          state_d  = B0;
          asm_d    = '0;
          complete = 1'b1;
        end
      endcase
    end else if (state_q != B0 && TIMEOUT != 0) begin
      // The edge that completes TIMEOUT idle cycles drops the partial word
      if (int'(idle_q) + 1 >= TIMEOUT) begin
        state_d = B0;
        asm_d   = '0;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  // FIFO control: push/pop decisions, pointer and count updates, sticky overflow
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    pop     = recv_pop && (count_q != '0);
    push    = complete && (!full || pop);
    ovf_set = complete && full && !pop;
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Control state registers; reset overrides every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= B0;
      asm_q      <= '0;
      idle_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      idle_q     <= idle_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage is not reset; a write is suppressed on a reset edge
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[tail_q] <= word;
    end
  end

  // Show-ahead outputs straight from storage and state
  always_comb begin
    recv_data  = mem_q[head_q];
    recv_valid = (count_q != '0);
    recv_count = count_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_recv_word_buffer.sv
// tb/tb_recv_word_buffer.sv - randomized self-checking bench for recv_word_buffer
module tb_recv_word_buffer;

  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        recv_pop;
  logic [31:0] recv_data;
  logic        recv_valid;
  logic [4:0]  recv_count;
  logic        overflow;
  logic        overflow_clr;

  int vectors;
  int miscompares;

  logic [31:0] mq[$];
  logic [7:0]  part[$];
  int          idle;
  logic        movf;

  recv_word_buffer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .recv_pop     (recv_pop),
    .recv_data    (recv_data),
    .recv_valid   (recv_valid),
    .recv_count   (recv_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
`ifdef RECV_BYTESWAP_EN
    return {d, c, b, a};
`else
    return {a, b, c, d};
`endif
  endfunction

  // One clock: drive inputs, advance the reference model, return at the falling edge
  task automatic step(input logic v, input logic [7:0] b, input logic p,
                      input logic c, input logic r);
    int          pre;
    logic        popok;
    logic        done;
    logic [31:0] w;
    rx_byte_valid = v; rx_byte = b; recv_pop = p; overflow_clr = c; reset = r;
    @(posedge clk);
    if (r) begin
      mq.delete(); part.delete(); idle = 0; movf = 1'b0;
    end else begin
      pre   = mq.size();
      popok = p && (pre > 0);
      done  = 1'b0;
      w     = '0;
      if (v) begin
        part.push_back(b);
        idle = 0;
        if (part.size() == 4) begin
          w = mk(part[0], part[1], part[2], part[3]);
          done = 1'b1;
          part.delete();
        end
      end else if (part.size() > 0) begin
        idle++;
        if (idle >= TMO) begin
          part.delete();
          idle = 0;
        end
      end
      if (popok) void'(mq.pop_front());
      if (done && (pre < DEPTH || popok)) mq.push_back(w);
      if (done && pre == DEPTH && !popok) movf = 1'b1;
      else if (c) movf = 1'b0;
    end
    @(negedge clk);
    rx_byte_valid = 1'b0; recv_pop = 1'b0; overflow_clr = 1'b0; reset = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic pop_last, input logic clr_last);
    step(1'b1, b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, b2, 1'b0, 1'b0, 1'b0);
    step(1'b1, b3, pop_last, clr_last, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++; if (recv_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", recv_valid); end
    vectors++; if (recv_count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", recv_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_push();
    logic [31:0] exp;
`ifdef RECV_BYTESWAP_EN
    exp = 32'h78563412;
`else
    exp = 32'h12345678;
`endif
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h56, 1'b0, 1'b0, 1'b0);
    vectors++; if (recv_valid !== 1'b0) begin miscompares++; $display("FAIL push_early_valid got %0b want 0", recv_valid); end
    step(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    vectors++; if (recv_valid !== 1'b1) begin miscompares++; $display("FAIL push_valid got %0b want 1", recv_valid); end
    vectors++; if (recv_data !== exp) begin miscompares++; $display("FAIL push_data got %h want %h", recv_data, exp); end
    vectors++; if (recv_count !== 5'd1) begin miscompares++; $display("FAIL push_count got %0d want 1", recv_count); end
  endtask

  task automatic test_overflow();
    logic [31:0] ow [17];
    logic [7:0]  b [4];
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
      ow[i] = mk(b[0], b[1], b[2], b[3]);
      send_word(b[0], b[1], b[2], b[3], 1'b0, 1'b0);
    end
    vectors++; if (recv_count !== 5'd16) begin miscompares++; $display("FAIL ovf_count got %0d want 16", recv_count); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    vectors++; if (recv_data !== ow[0]) begin miscompares++; $display("FAIL ovf_head got %h want %h", recv_data, ow[0]); end
    send_word(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b1);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins got %0b want 1", overflow); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %0b want 0", overflow); end
    send_word(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1'b1, 1'b0);
    vectors++; if (recv_count !== 5'd16) begin miscompares++; $display("FAIL full_pushpop_count got %0d want 16", recv_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_pushpop_ovf got %0b want 0", overflow); end
    vectors++; if (recv_data !== ow[1]) begin miscompares++; $display("FAIL full_pushpop_head got %h want %h", recv_data, ow[1]); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (recv_data !== mq[0]) begin miscompares++; $display("FAIL drain_data[%0d] got %h want %h", i, recv_data, mq[0]); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    vectors++; if (recv_count !== 5'd0) begin miscompares++; $display("FAIL drain_count got %0d want 0", recv_count); end
  endtask

  task automatic test_pop_empty();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++; if (recv_count !== 5'd0) begin miscompares++; $display("FAIL pop_empty_count got %0d want 0", recv_count); end
    send_word(8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b1, 1'b0);
    vectors++; if (recv_count !== 5'd1) begin miscompares++; $display("FAIL empty_pushpop_count got %0d want 1", recv_count); end
    vectors++; if (recv_valid !== 1'b1) begin miscompares++; $display("FAIL empty_pushpop_valid got %0b want 1", recv_valid); end
    vectors++; if (recv_data !== mk(8'hDE, 8'hAD, 8'hBE, 8'hEF)) begin miscompares++; $display("FAIL empty_pushpop_data got %h", recv_data); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++; if (recv_count !== 5'd0) begin miscompares++; $display("FAIL last_pop_count got %0d want 0", recv_count); end
  endtask

  task automatic test_timeout();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TMO; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    send_word(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0, 1'b0);
    vectors++; if (recv_count !== 5'd1) begin miscompares++; $display("FAIL timeout_count got %0d want 1", recv_count); end
    vectors++; if (recv_data !== mk(8'hAA, 8'hBB, 8'hCC, 8'hDD)) begin miscompares++; $display("FAIL timeout_data got %h want %h", recv_data, mk(8'hAA, 8'hBB, 8'hCC, 8'hDD)); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TMO - 1; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    vectors++; if (recv_data !== mk(8'h11, 8'h22, 8'hAA, 8'hBB) || recv_count !== 5'd1) begin
      miscompares++; $display("FAIL no_timeout_word got %h/%0d want %h/1", recv_data, recv_count, mk(8'h11, 8'h22, 8'hAA, 8'hBB));
    end
  endtask

  task automatic test_wrap();
    int          nexp;
    logic        p;
    logic [31:0] w;
    logic [7:0]  b;
    nexp = 0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      w = 32'(i);
      for (int k = 0; k < 4; k++) begin
`ifdef RECV_BYTESWAP_EN
        b = w[8*k +: 8];
`else
        b = w[8*(3-k) +: 8];
`endif
        p = 1'($urandom_range(0, 1));
        if (p && recv_valid) begin
          vectors++; if (recv_data !== 32'(nexp)) begin miscompares++; $display("FAIL wrap_order got %h want %h", recv_data, 32'(nexp)); end
          nexp++;
        end
        step(1'b1, b, p, 1'b0, 1'b0);
        if (recv_count > 5'd16) begin miscompares++; $display("FAIL wrap_bound got %0d want <=16", recv_count); end
      end
    end
    for (int g = 0; g < 64 && recv_valid; g++) begin
      vectors++; if (recv_data !== 32'(nexp)) begin miscompares++; $display("FAIL wrap_drain got %h want %h", recv_data, 32'(nexp)); end
      nexp++;
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    vectors++; if (nexp != 40) begin miscompares++; $display("FAIL wrap_total got %0d want 40", nexp); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_word(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0);
    send_word(8'h05, 8'h06, 8'h07, 8'h08, 1'b0, 1'b0);
    step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0C, 1'b1, 1'b0, 1'b1);
    vectors++; if (recv_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid got %0b want 0", recv_valid); end
    vectors++; if (recv_count !== 5'd0) begin miscompares++; $display("FAIL midreset_count got %0d want 0", recv_count); end
    send_word(8'hF1, 8'hF2, 8'hF3, 8'hF4, 1'b0, 1'b0);
    vectors++; if (recv_data !== mk(8'hF1, 8'hF2, 8'hF3, 8'hF4) || recv_count !== 5'd1) begin
      miscompares++; $display("FAIL midreset_fresh got %h/%0d want %h/1", recv_data, recv_count, mk(8'hF1, 8'hF2, 8'hF3, 8'hF4));
    end
  endtask

  task automatic test_random();
    logic v, p, c, r;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1200; i++) begin
      v = ($urandom_range(0, 9) < 4);
      p = (i < 600) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 399) == 0);
      step(v, 8'($urandom), p, c, r);
      vectors++;
      if (recv_valid !== (mq.size() != 0) || recv_count !== 5'(mq.size()) || overflow !== movf ||
          (mq.size() != 0 && recv_data !== mq[0])) begin
        miscompares++;
        $display("FAIL random[%0d] got v=%0b n=%0d o=%0b d=%h want v=%0b n=%0d o=%0b d=%h", i,
                 recv_valid, recv_count, overflow, recv_data, mq.size() != 0, mq.size(), movf,
                 (mq.size() != 0) ? mq[0] : 32'h0);
      end
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; rx_byte = 8'h00; rx_byte_valid = 1'b0;
    recv_pop = 1'b0; overflow_clr = 1'b0;
    vectors = 0; miscompares = 0; idle = 0; movf = 1'b0;
    test_reset();
    test_push();
    test_overflow();
    test_pop_empty();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
